// File: rtl/dram_model.sv
// Behavioural backing-store DRAM: single-word requests serviced after a fixed LATENCY.
// Optional DRAM_STATS_EN adds saturating completed-read/write counters.
module dram_model #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef DRAM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [7:0]  LOAD  = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND, DRAIN} state_t;

    state_t            state;
    logic [7:0]        count;
    logic [ADDR_W-1:0] idx;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] addr_idx;
    logic              go_respond;
    logic              go_we;
    logic [ADDR_W-1:0] go_idx;
    logic              unused_addr;

    assign addr_idx    = mem_addr[ADDR_W+1:2];
    assign unused_addr = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    // Entry into RESPOND: from IDLE only when LATENCY=1, otherwise at the last WAIT edge.
    always_comb begin
        go_respond = 1'b0;
        go_we      = we;
        go_idx     = idx;
        if (state == IDLE) begin
            go_we      = mem_we;
            go_idx     = addr_idx;
            go_respond = mem_req && (LATENCY == 1);
        end else if (state == WAIT) begin
            go_respond = mem_req && (count == 8'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 8'd0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            busy      <= 1'b0;
            idx       <= '0;
            we        <= 1'b0;
            wdata     <= '0;
`ifdef DRAM_STATS_EN
            rd_count  <= 16'd0;
            wr_count  <= 16'd0;
`endif
        end else begin
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        idx   <= addr_idx;
                        we    <= mem_we;
                        wdata <= mem_wdata;
                        count <= LOAD;
                        busy  <= 1'b1;
                        state <= (LATENCY == 1) ? RESPOND : WAIT;
                    end
                end
                WAIT: begin
                    count <= count - 8'd1;
                    if (!mem_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (count == 8'd1) begin
                        state <= RESPOND;
                    end
                end
                RESPOND: begin
                    // Write commits on the exit edge so a reset in RESPOND suppresses it.
                    if (we) begin
                        mem[idx] <= wdata;
                    end
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!mem_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (go_respond) begin
                mem_ready <= 1'b1;
                if (!go_we) begin
                    mem_rdata <= mem[go_idx];
                end
`ifdef DRAM_STATS_EN
                if (go_we) begin
                    if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                end else begin
                    if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                end
`endif
            end
        end
    end

endmodule
